// File: rtl/nios2_oci_dct_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : nios2_oci_dct_pkg
// Brief  : State encoding and count-width helper shared by the DCT capture RTL.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
package nios2_oci_dct_pkg;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } dct_state_e;

  function automatic int count_width(input int slots);
    return $clog2(slots + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/nios2_oci_dct_packer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : nios2_oci_dct_packer
// Brief  : Multi-slot entry register with fill counter; write, clear, bulk load.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
module nios2_oci_dct_packer
  import nios2_oci_dct_pkg::*;
#(
  parameter int ENTRY_W = 10,
  parameter int SLOTS   = 3
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            clr,
  input  logic                            wr,
  input  logic [ENTRY_W-1:0]              wr_data,
  input  logic                            ld,
  input  logic [ENTRY_W*SLOTS-1:0]        ld_data,
  input  logic [count_width(SLOTS)-1:0]   ld_count,
  output logic [ENTRY_W*SLOTS-1:0]        data,
  output logic [count_width(SLOTS)-1:0]   fill,
  output logic                            full
);

  localparam int c_cnt_w = count_width(SLOTS);
  localparam logic [c_cnt_w-1:0] c_slots = c_cnt_w'(SLOTS);

  logic [ENTRY_W*SLOTS-1:0] r_data;
  logic [ENTRY_W*SLOTS-1:0] w_data_nxt;
  logic [c_cnt_w-1:0]       r_fill;
  logic [c_cnt_w-1:0]       w_fill_nxt;
  logic [c_cnt_w-1:0]       w_idx;

  // clr together with wr restarts the register with the new entry in slot 0
  always_comb begin
    w_idx      = clr ? '0 : r_fill;
    w_data_nxt = clr ? '0 : r_data;
    w_fill_nxt = w_idx;
    if (ld) begin
      w_data_nxt = ld_data;
      w_fill_nxt = ld_count;
    end else if (wr && (w_idx != c_slots)) begin
      for (int i = 0; i < SLOTS; i++) begin
        if (w_idx == c_cnt_w'(i)) begin
          w_data_nxt[i*ENTRY_W +: ENTRY_W] = wr_data;
        end
      end
      w_fill_nxt = w_idx + c_cnt_w'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data <= '0;
      r_fill <= '0;
    end else begin
      r_data <= w_data_nxt;
      r_fill <= w_fill_nxt;
    end
  end

  assign data = r_data;
  assign fill = r_fill;
  assign full = (r_fill == c_slots);

endmodule
`default_nettype wire

// File: rtl/nios2_oci_dct_capture.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : nios2_oci_dct_capture
// Brief  : Packs trace entries into DCT buffers on a valid/ready output, flushes
//          at test end, counts back-pressure drops. Optional timestamp port via
//          NIOS2_OCI_DCT_TIMESTAMP_EN.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
module nios2_oci_dct_capture
  import nios2_oci_dct_pkg::*;
#(
  parameter int ENTRY_W = 10,
  parameter int SLOTS   = 3,
  parameter int DROP_W  = 8,
  parameter int TS_W    = 32
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           trace_valid,
  input  logic [ENTRY_W-1:0]             trace_data,
  input  logic                           test_ending,
  input  logic                           test_has_ended,
  input  logic                           buf_ready,
  output logic                           buf_valid,
  output logic [ENTRY_W*SLOTS-1:0]       dct_buffer,
  output logic [count_width(SLOTS)-1:0]  dct_count,
  output logic [DROP_W-1:0]              drop_count,
`ifdef NIOS2_OCI_DCT_TIMESTAMP_EN
  output logic [TS_W-1:0]                dct_timestamp,
`endif
  output logic                           done
);

  localparam int c_cnt_w = count_width(SLOTS);

  dct_state_e               r_state;
  dct_state_e               w_state_nxt;
  logic                     r_ending;
  logic                     w_ending_nxt;
  logic                     r_buf_valid;
  logic                     w_valid_nxt;
  logic [DROP_W-1:0]        r_drop;
  logic                     w_drop_inc;
  logic                     w_out_ld;
  logic                     w_work_clr;
  logic                     w_work_wr;
  logic                     w_xfer;
  logic                     w_ending;
  logic [ENTRY_W*SLOTS-1:0] w_work_data;
  logic [c_cnt_w-1:0]       w_work_fill;
  logic                     w_work_full;
  logic                     w_out_full_unused;

  assign w_xfer   = r_buf_valid && buf_ready;
  assign w_ending = r_ending || test_ending;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_FILL;
      r_ending    <= 1'b0;
      r_buf_valid <= 1'b0;
      r_drop      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_ending    <= w_ending_nxt;
      r_buf_valid <= w_valid_nxt;
      if (w_drop_inc && (r_drop != {DROP_W{1'b1}})) begin
        r_drop <= r_drop + DROP_W'(1);
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_ending_nxt = r_ending;
    w_valid_nxt  = r_buf_valid && !buf_ready;
    w_out_ld     = 1'b0;
    w_work_clr   = 1'b0;
    w_work_wr    = 1'b0;
    w_drop_inc   = 1'b0;
    case (r_state)
      ST_FILL: begin
        if (test_has_ended) begin
          w_work_clr  = 1'b1;
          w_state_nxt = ST_DONE;
        end else if (r_ending) begin
          w_drop_inc = trace_valid;
          if (w_work_fill != '0) begin
            w_out_ld    = 1'b1;
            w_valid_nxt = 1'b1;
            w_work_clr  = 1'b1;
            w_state_nxt = ST_FLUSH;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end else begin
          w_ending_nxt = test_ending;
          w_work_wr    = trace_valid;
          // a full working register moves out while the new entry lands in slot 0
          if (w_work_full) begin
            w_out_ld    = 1'b1;
            w_valid_nxt = 1'b1;
            w_work_clr  = 1'b1;
            w_state_nxt = ST_HOLD;
          end else if (test_ending && !trace_valid && (w_work_fill == '0)) begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_HOLD: begin
        if (test_has_ended) begin
          w_work_clr  = 1'b1;
          w_state_nxt = ST_DONE;
        end else begin
          w_ending_nxt = w_ending;
          if (trace_valid) begin
            if (!r_ending && !w_work_full) w_work_wr = 1'b1;
            else                           w_drop_inc = 1'b1;
          end
          if (w_xfer) begin
            if (w_work_full) begin
              w_out_ld    = 1'b1;
              w_valid_nxt = 1'b1;
              w_work_clr  = 1'b1;
            end else if (w_ending && (w_work_fill == '0) && !w_work_wr) begin
              w_state_nxt = ST_DONE;
            end else begin
              w_state_nxt = ST_FILL;
            end
          end
        end
      end
      ST_FLUSH: begin
        if (test_has_ended) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_drop_inc = trace_valid;
          if (w_xfer) w_state_nxt = ST_DONE;
        end
      end
      default: ;
    endcase
  end

  nios2_oci_dct_packer #(
    .ENTRY_W (ENTRY_W),
    .SLOTS   (SLOTS)
  ) u_work (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (w_work_clr),
    .wr       (w_work_wr),
    .wr_data  (trace_data),
    .ld       (1'b0),
    .ld_data  ('0),
    .ld_count ('0),
    .data     (w_work_data),
    .fill     (w_work_fill),
    .full     (w_work_full)
  );

  nios2_oci_dct_packer #(
    .ENTRY_W (ENTRY_W),
    .SLOTS   (SLOTS)
  ) u_out (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (1'b0),
    .wr       (1'b0),
    .wr_data  ('0),
    .ld       (w_out_ld),
    .ld_data  (w_work_data),
    .ld_count (w_work_fill),
    .data     (dct_buffer),
    .fill     (dct_count),
    .full     (w_out_full_unused)
  );

`ifdef NIOS2_OCI_DCT_TIMESTAMP_EN
  logic [TS_W-1:0] r_ts;
  logic [TS_W-1:0] r_work_ts;
  logic [TS_W-1:0] r_out_ts;

  // the stamp follows slot 0 from the working register to the output register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ts      <= '0;
      r_work_ts <= '0;
      r_out_ts  <= '0;
    end else begin
      r_ts <= r_ts + TS_W'(1);
      if (w_work_wr && (w_work_clr || (w_work_fill == '0))) r_work_ts <= r_ts;
      if (w_out_ld) r_out_ts <= r_work_ts;
    end
  end

  assign dct_timestamp = r_out_ts;
`else
  localparam int c_ts_w_unused = TS_W;
`endif

  assign buf_valid  = r_buf_valid;
  assign drop_count = r_drop;
  assign done       = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_nios2_oci_dct_capture.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : tb_nios2_oci_dct_capture
// Brief  : Vector-table and directed-sequence bench for nios2_oci_dct_capture.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
module tb_nios2_oci_dct_capture;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        trace_valid = 1'b0;
  logic [9:0]  trace_data = '0;
  logic        test_ending = 1'b0;
  logic        test_has_ended = 1'b0;
  logic        buf_ready = 1'b0;

  logic        buf_valid, buf_valid_s;
  logic [29:0] dct_buffer, dct_buffer_s;
  logic [1:0]  dct_count, dct_count_s;
  logic [7:0]  drop_count;
  logic [1:0]  drop_count_s;
  logic        done, done_s;
`ifdef NIOS2_OCI_DCT_TIMESTAMP_EN
  logic [31:0] dct_timestamp, dct_timestamp_s;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  nios2_oci_dct_capture u_dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .trace_valid    (trace_valid),
    .trace_data     (trace_data),
    .test_ending    (test_ending),
    .test_has_ended (test_has_ended),
    .buf_ready      (buf_ready),
    .buf_valid      (buf_valid),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .drop_count     (drop_count),
`ifdef NIOS2_OCI_DCT_TIMESTAMP_EN
    .dct_timestamp  (dct_timestamp),
`endif
    .done           (done)
  );

  nios2_oci_dct_capture #(.DROP_W(2)) u_dut_sat (
    .clk            (clk),
    .reset_n        (reset_n),
    .trace_valid    (trace_valid),
    .trace_data     (trace_data),
    .test_ending    (test_ending),
    .test_has_ended (test_has_ended),
    .buf_ready      (buf_ready),
    .buf_valid      (buf_valid_s),
    .dct_buffer     (dct_buffer_s),
    .dct_count      (dct_count_s),
    .drop_count     (drop_count_s),
`ifdef NIOS2_OCI_DCT_TIMESTAMP_EN
    .dct_timestamp  (dct_timestamp_s),
`endif
    .done           (done_s)
  );

  typedef struct {
    logic        tv;
    logic [9:0]  d;
    logic        te;
    logic        th;
    logic        rdy;
    logic        ev;
    logic [29:0] eb;
    logic [1:0]  ec;
    logic [7:0]  ed;
    logic        edn;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic [3:0] in, input logic [9:0] d, input logic ev,
                              input logic [29:0] eb, input logic [1:0] ec,
                              input logic [7:0] ed, input logic edn);
    vec_t v;
    v.tv = in[3]; v.te = in[2]; v.th = in[1]; v.rdy = in[0];
    v.d = d; v.ev = ev; v.eb = eb; v.ec = ec; v.ed = ed; v.edn = edn;
    vq.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic tv, input logic [9:0] d, input logic te,
                       input logic th, input logic rdy);
    trace_valid = tv; trace_data = d; test_ending = te; test_has_ended = th; buf_ready = rdy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    drive(1'b0, 10'h0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // {trace_valid, test_ending, test_has_ended, buf_ready}
    add(4'b1001, 10'h001, 1'b0, 30'h0,        2'd0, 8'd0, 1'b0);
    add(4'b1001, 10'h002, 1'b0, 30'h0,        2'd0, 8'd0, 1'b0);
    add(4'b1001, 10'h003, 1'b0, 30'h0,        2'd0, 8'd0, 1'b0);
    add(4'b0001, 10'h000, 1'b1, 30'h00300801, 2'd3, 8'd0, 1'b0);
    add(4'b0001, 10'h000, 1'b0, 30'h0,        2'd0, 8'd0, 1'b0);
    // back-pressure: ten cycles without ready, eight entries
    add(4'b1000, 10'h011, 1'b0, 30'h0,        2'd0, 8'd0, 1'b0);
    add(4'b1000, 10'h012, 1'b0, 30'h0,        2'd0, 8'd0, 1'b0);
    add(4'b1000, 10'h013, 1'b0, 30'h0,        2'd0, 8'd0, 1'b0);
    add(4'b1000, 10'h014, 1'b1, 30'h01304811, 2'd3, 8'd0, 1'b0);
    add(4'b1000, 10'h015, 1'b1, 30'h01304811, 2'd3, 8'd0, 1'b0);
    add(4'b1000, 10'h016, 1'b1, 30'h01304811, 2'd3, 8'd0, 1'b0);
    add(4'b1000, 10'h017, 1'b1, 30'h01304811, 2'd3, 8'd1, 1'b0);
    add(4'b1000, 10'h018, 1'b1, 30'h01304811, 2'd3, 8'd2, 1'b0);
    add(4'b0000, 10'h000, 1'b1, 30'h01304811, 2'd3, 8'd2, 1'b0);
    add(4'b0000, 10'h000, 1'b1, 30'h01304811, 2'd3, 8'd2, 1'b0);
    add(4'b0001, 10'h000, 1'b1, 30'h01605414, 2'd3, 8'd2, 1'b0);
    add(4'b0001, 10'h000, 1'b0, 30'h0,        2'd0, 8'd2, 1'b0);
    // partial flush on test_ending
    add(4'b1000, 10'h155, 1'b0, 30'h0,        2'd0, 8'd2, 1'b0);
    add(4'b1000, 10'h0AA, 1'b0, 30'h0,        2'd0, 8'd2, 1'b0);
    add(4'b0100, 10'h000, 1'b0, 30'h0,        2'd0, 8'd2, 1'b0);
    add(4'b0000, 10'h000, 1'b1, 30'h0002A955, 2'd2, 8'd2, 1'b0);
    add(4'b0000, 10'h000, 1'b1, 30'h0002A955, 2'd2, 8'd2, 1'b0);
    add(4'b0001, 10'h000, 1'b0, 30'h0,        2'd0, 8'd2, 1'b1);
    add(4'b1000, 10'h3FF, 1'b0, 30'h0,        2'd0, 8'd2, 1'b1);
    add(4'b0110, 10'h000, 1'b0, 30'h0,        2'd0, 8'd2, 1'b1);

    do_reset();
    check("reset.buf_valid",  32'(buf_valid),  32'd0);
    check("reset.dct_buffer", 32'(dct_buffer), 32'd0);
    check("reset.dct_count",  32'(dct_count),  32'd0);
    check("reset.drop_count", 32'(drop_count), 32'd0);
    check("reset.done",       32'(done),       32'd0);

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].tv, vq[i].d, vq[i].te, vq[i].th, vq[i].rdy);
      step();
      check($sformatf("vec%0d.buf_valid", i),  32'(buf_valid),  32'(vq[i].ev));
      check($sformatf("vec%0d.drop_count", i), 32'(drop_count), 32'(vq[i].ed));
      check($sformatf("vec%0d.done", i),       32'(done),       32'(vq[i].edn));
      if (vq[i].ev) begin
        check($sformatf("vec%0d.dct_buffer", i), 32'(dct_buffer), 32'(vq[i].eb));
        check($sformatf("vec%0d.dct_count", i),  32'(dct_count),  32'(vq[i].ec));
      end
    end

    // test_ending with nothing pending: done on the next cycle
    do_reset();
    drive(1'b0, 10'h0, 1'b1, 1'b0, 1'b0);
    step();
    check("end_empty.done",      32'(done),      32'd1);
    check("end_empty.buf_valid", 32'(buf_valid), 32'd0);

    // entry in the same cycle as test_ending is flushed as a one-slot buffer
    do_reset();
    drive(1'b1, 10'h2C3, 1'b1, 1'b0, 1'b0);
    step();
    check("end_same.buf_valid0", 32'(buf_valid), 32'd0);
    drive(1'b0, 10'h0, 1'b0, 1'b0, 1'b0);
    step();
    check("end_same.buf_valid1", 32'(buf_valid),  32'd1);
    check("end_same.dct_buffer", 32'(dct_buffer), 32'h2C3);
    check("end_same.dct_count",  32'(dct_count),  32'd1);
    check("end_same.done0",      32'(done),       32'd0);
    drive(1'b1, 10'h111, 1'b0, 1'b0, 1'b1);
    step();
    check("end_same.done1",      32'(done),       32'd1);
    check("end_same.buf_valid2", 32'(buf_valid),  32'd0);
    check("end_same.drop",       32'(drop_count), 32'd1);

    // abort discards the partial buffer; later test_ending has no effect
    do_reset();
    drive(1'b1, 10'h0F0, 1'b0, 1'b0, 1'b1);
    step();
    drive(1'b0, 10'h0, 1'b0, 1'b1, 1'b1);
    step();
    check("abort.done",       32'(done),      32'd1);
    check("abort.buf_valid0", 32'(buf_valid), 32'd0);
    drive(1'b1, 10'h001, 1'b1, 1'b0, 1'b1);
    step();
    drive(1'b0, 10'h0, 1'b0, 1'b0, 1'b1);
    repeat (2) step();
    check("abort.buf_valid1", 32'(buf_valid),  32'd0);
    check("abort.drop",       32'(drop_count), 32'd0);
    check("abort.done_stay",  32'(done),       32'd1);

    // six drops saturate the two-bit counter; async reset kills the handshake
    do_reset();
    drive(1'b1, 10'h3C3, 1'b0, 1'b0, 1'b0);
    repeat (12) step();
    check("sat.drop8",     32'(drop_count),   32'd6);
    check("sat.drop2",     32'(drop_count_s), 32'd3);
    check("sat.buf_valid", 32'(buf_valid),    32'd1);
    reset_n = 1'b0;
    #1;
    check("async_rst.buf_valid",  32'(buf_valid),  32'd0);
    check("async_rst.dct_buffer", 32'(dct_buffer), 32'd0);
    check("async_rst.drop",       32'(drop_count), 32'd0);

`ifdef NIOS2_OCI_DCT_TIMESTAMP_EN
    do_reset();
    repeat (5) step();
    drive(1'b1, 10'h001, 1'b0, 1'b0, 1'b0);
    repeat (3) step();
    drive(1'b0, 10'h0, 1'b0, 1'b0, 1'b0);
    step();
    check("ts.buf_valid", 32'(buf_valid),     32'd1);
    check("ts.value",     32'(dct_timestamp), 32'd5);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
